apb_slave_mem: RTL and testbench

- APB3 completer: the responder end of the APB master interface driven by the AXI-to-APB bridge.
- Contains a small word-addressed register memory.
- Inserts a per-transfer programmable number of wait states.
- Flags unaligned or out-of-range accesses with PSLVERR.
- One instance sits on each bridge psel line; it is also the bench's reference APB target.

---
 rtl/apb_slave_mem.sv | 124 ++++++++++++
 tb/tb_apb_slave_mem.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// APB3 completer with a small word-addressed register memory, per-transfer
// programmable wait states and a completed-transfer counter.
// Optional macro APB_SLV_ERR_EN: when defined, unaligned or out-of-range
// accesses complete with pslverr_o=1 (writes dropped, reads return 0);
// when undefined, addresses alias modulo DEPTH and pslverr_o is tied low.
module apb_slave_mem #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [DATA_WIDTH-1:0] pwdata_i,
    input  logic                  pwrite_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    output logic [DATA_WIDTH-1:0] prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    input  logic [2:0]            wait_cfg_i,
    output logic [15:0]           xfer_cnt_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [IDX_W-1:0]        idx_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [2:0]              wcnt_q;
    logic                    err_q;
    logic [15:0]             xfer_cnt_q;

    logic [ADDR_WIDTH-1:0]   offset_d;
    logic [IDX_W-1:0]        idx_d;
    logic                    err_d;
    logic                    complete_d;

    // Word index of the setup address relative to the base (aliases modulo DEPTH)
    always_comb begin
        offset_d = paddr_i - BASE_ADDR;
        idx_d    = IDX_W'(offset_d >> 2);
    end

`ifdef APB_SLV_ERR_EN
    // One extra bit keeps BASE_ADDR + 4*DEPTH from wrapping at the top of the map
    localparam logic [ADDR_WIDTH:0] LIMIT = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(4 * DEPTH);

    // Setup-phase error decode: unaligned, below base, or past the last word
    always_comb begin
        err_d = (paddr_i[1:0] != 2'b00)
             || ({1'b0, paddr_i} < {1'b0, BASE_ADDR})
             || ({1'b0, paddr_i} >= LIMIT);
    end
`else
    assign err_d = 1'b0;
`endif

    // Protocol FSM, wait counter, memory and transfer counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wcnt_q     <= '0;
            err_q      <= 1'b0;
            xfer_cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == IDLE) begin
            // Setup phase only; psel with penable in IDLE is ignored
            if (psel_i && !penable_i) begin
                idx_q   <= idx_d;
                write_q <= pwrite_i;
                wdata_q <= pwdata_i;
                wcnt_q  <= wait_cfg_i;
                err_q   <= err_d;
                if (!pwrite_i && !err_d) begin
                    rdata_q <= mem_q[idx_d];
                end
                state_q <= ACCESS;
            end
        end else begin
            if (!psel_i || !penable_i) begin
                state_q <= IDLE;
            end else if (wcnt_q != '0) begin
                wcnt_q <= wcnt_q - 3'd1;
            end else begin
                if (write_q && !err_q) begin
                    mem_q[idx_q] <= wdata_q;
                end
                xfer_cnt_q <= xfer_cnt_q + 16'd1;
                state_q    <= IDLE;
            end
        end
    end

    // Completion is decoded from registered state so the responses stay 0 elsewhere
    always_comb begin
        complete_d = (state_q == ACCESS) && psel_i && penable_i && (wcnt_q == '0);
        pready_o   = complete_d;
        prdata_o   = (complete_d && !write_q && !err_q) ? rdata_q : '0;
`ifdef APB_SLV_ERR_EN
        pslverr_o  = complete_d && err_q;
`else
        pslverr_o  = 1'b0;
`endif
    end

    assign xfer_cnt_o = xfer_cnt_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem with a behavioural memory model.
module tb_apb_slave_mem;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic [DW-1:0] prdata_o;
    logic          pready_o;
    logic          pslverr_o;
    logic [2:0]    wait_cfg;
    logic [15:0]   xfer_cnt_o;

    always #5 clk = ~clk;

    apb_slave_mem #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .paddr_i(paddr),
        .pwdata_i(pwdata),
        .pwrite_i(pwrite),
        .psel_i(psel),
        .penable_i(penable),
        .prdata_o(prdata_o),
        .pready_o(pready_o),
        .pslverr_o(pslverr_o),
        .wait_cfg_i(wait_cfg),
        .xfer_cnt_o(xfer_cnt_o)
    );

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain array of words plus a completion counter
    logic [31:0] mem_m [DEPTH];
    logic [15:0] cnt_m;

    function automatic logic model_err(input logic [31:0] a);
`ifdef APB_SLV_ERR_EN
        longint unsigned la;
        la = a;
        return ((a % 4) != 0) || (la < BASE) || (la >= longint'(BASE) + 4 * DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int unsigned model_idx(input logic [31:0] a);
        logic [31:0] d;
        d = a - BASE;
        return (d / 4) % DEPTH;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        cnt_m = '0;
    endtask

    task automatic model_xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er);
        er = model_err(a);
        rd = '0;
        if (!er) begin
            if (wr) mem_m[model_idx(a)] = wd;
            else    rd = mem_m[model_idx(a)];
        end
        cnt_m = cnt_m + 16'd1;
    endtask

    // Drives one full transfer; returns the response and the number of access
    // cycles seen with pready low. leak flags any nonzero response outside completion.
    task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            input logic [2:0] wc, output logic [31:0] rd, output logic er,
                            output int waits, output logic leak);
        int   guard;
        logic done;
        rd = '0; er = 1'b0; waits = 0; leak = 1'b0; done = 1'b0; guard = 0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; wait_cfg = wc;
        #1;
        if (pready_o || pslverr_o || prdata_o != '0) leak = 1'b1;
        @(posedge clk); #1;
        // address, data and wait config must be ignored once in access
        penable = 1'b1; paddr = $urandom; pwdata = $urandom; wait_cfg = 3'($urandom);
        while (!done && guard < 20) begin
            #1;
            if (pready_o) begin
                done = 1'b1;
                rd   = prdata_o;
                er   = pslverr_o;
            end else begin
                if (pslverr_o || prdata_o != '0) leak = 1'b1;
                waits++;
                guard++;
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL xfer_timeout: pready not seen after %0d access cycles, required after %0d", guard, wc);
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; wait_cfg = '0;
        @(posedge clk); #2;
        total++; if (pready_o !== 1'b0) begin bad++; $display("FAIL reset_pready: got %b want 0", pready_o); end
        total++; if (pslverr_o !== 1'b0) begin bad++; $display("FAIL reset_pslverr: got %b want 0", pslverr_o); end
        total++; if (prdata_o !== 32'h0) begin bad++; $display("FAIL reset_prdata: got %h want 0", prdata_o); end
        total++; if (xfer_cnt_o !== 16'h0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", xfer_cnt_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_basic();
        logic [31:0] rd, erd; logic er, eer, leak; int w;
        apb_xfer(1'b1, BASE + 32'h8, 32'hDEAD_BEEF, 3'd0, rd, er, w, leak);
        model_xfer(1'b1, BASE + 32'h8, 32'hDEAD_BEEF, erd, eer);
        total++; if (w !== 0) begin bad++; $display("FAIL basic_wr_wait: got %0d want 0", w); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL basic_wr_err: got %b want 0", er); end
        apb_xfer(1'b0, BASE + 32'h8, 32'h0, 3'd0, rd, er, w, leak);
        model_xfer(1'b0, BASE + 32'h8, 32'h0, erd, eer);
        total++; if (w !== 0) begin bad++; $display("FAIL basic_rd_wait: got %0d want 0", w); end
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL basic_rd_data: got %h want deadbeef", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL basic_rd_err: got %b want 0", er); end
        go_idle();
        #1;
        total++; if (xfer_cnt_o !== 16'd2) begin bad++; $display("FAIL basic_cnt: got %0d want 2", xfer_cnt_o); end
    endtask

    task automatic test_wait();
        logic [31:0] rd; logic er, leak; int w;
        apply_reset();
        apb_xfer(1'b0, BASE, 32'h0, 3'd5, rd, er, w, leak);
        cnt_m = cnt_m + 16'd1;
        total++; if (w !== 5) begin bad++; $display("FAIL wait5_cycles: got %0d want 5", w); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL wait5_data: got %h want 0", rd); end
        total++; if (leak !== 1'b0) begin bad++; $display("FAIL wait5_leak: got %b want 0", leak); end
        go_idle();
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd; logic er, eer, leak; int w;
        apb_xfer(1'b1, BASE + 32'h40, 32'hCAFE_F00D, 3'd1, rd, er, w, leak);
        model_xfer(1'b1, BASE + 32'h40, 32'hCAFE_F00D, erd, eer);
        total++; if (er !== eer) begin bad++; $display("FAIL err_oor_wr: got %b want %b", er, eer); end
        apb_xfer(1'b0, BASE + 32'h2, 32'h0, 3'd0, rd, er, w, leak);
        model_xfer(1'b0, BASE + 32'h2, 32'h0, erd, eer);
        total++; if (er !== eer) begin bad++; $display("FAIL err_unal_rd: got %b want %b", er, eer); end
        total++; if (rd !== erd) begin bad++; $display("FAIL err_unal_data: got %h want %h", rd, erd); end
        for (int i = 0; i < 4; i++) begin
            apb_xfer(1'b0, BASE + 32'(4 * i), 32'h0, 3'd0, rd, er, w, leak);
            model_xfer(1'b0, BASE + 32'(4 * i), 32'h0, erd, eer);
            total++; if (rd !== erd) begin bad++; $display("FAIL err_mem_word%0d: got %h want %h", i, rd, erd); end
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, erd; logic er, eer, leak; int w;
        int unsigned c1;
        apb_xfer(1'b1, BASE + 32'hC, 32'h11, 3'd0, rd, er, w, leak);
        model_xfer(1'b1, BASE + 32'hC, 32'h11, erd, eer);
        c1 = cyc;
        apb_xfer(1'b0, BASE + 32'hC, 32'h0, 3'd0, rd, er, w, leak);
        model_xfer(1'b0, BASE + 32'hC, 32'h0, erd, eer);
        total++; if (rd !== 32'h11) begin bad++; $display("FAIL b2b_data: got %h want 11", rd); end
        total++; if (cyc - c1 !== 2) begin bad++; $display("FAIL b2b_cycles: got %0d want 2", cyc - c1); end
        go_idle();
    endtask

    task automatic test_abort();
        logic [31:0] rd, erd; logic er, eer, leak; int w;
        int seen;
        apb_xfer(1'b1, BASE + 32'h4, 32'hA5A5_0001, 3'd0, rd, er, w, leak);
        model_xfer(1'b1, BASE + 32'h4, 32'hA5A5_0001, erd, eer);
        go_idle();
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h4; pwdata = 32'h55; wait_cfg = 3'd3;
        seen = 0;
        @(posedge clk); #1;
        penable = 1'b1;
        #1; if (pready_o) seen++;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1; if (pready_o) seen++;
            @(posedge clk); #1;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_pready: got %0d completions want 0", seen); end
        total++; if (xfer_cnt_o !== cnt_m) begin bad++; $display("FAIL abort_cnt: got %0d want %0d", xfer_cnt_o, cnt_m); end
        apb_xfer(1'b0, BASE + 32'h4, 32'h0, 3'd0, rd, er, w, leak);
        model_xfer(1'b0, BASE + 32'h4, 32'h0, erd, eer);
        total++; if (rd !== erd) begin bad++; $display("FAIL abort_data: got %h want %h", rd, erd); end
        go_idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd; logic er, eer, leak; int w;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h8; pwdata = 32'h7777_7777; wait_cfg = 3'd7;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        total++; if (pready_o !== 1'b0) begin bad++; $display("FAIL rstmid_pready: got %b want 0", pready_o); end
        total++; if (xfer_cnt_o !== 16'h0) begin bad++; $display("FAIL rstmid_cnt: got %0d want 0", xfer_cnt_o); end
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            apb_xfer(1'b0, BASE + 32'(4 * i), 32'h0, 3'd0, rd, er, w, leak);
            model_xfer(1'b0, BASE + 32'(4 * i), 32'h0, erd, eer);
            total++; if (rd !== erd) begin bad++; $display("FAIL rstmid_word%0d: got %h want %h", i, rd, erd); end
        end
        go_idle();
    endtask

    task automatic test_protocol_violation();
        logic [31:0] rd, erd; logic er, eer, leak; int w;
        int seen;
        seen = 0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = BASE; pwdata = 32'hBAD0_BAD0; wait_cfg = 3'd0;
        for (int i = 0; i < 3; i++) begin
            #1; if (pready_o) seen++;
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        total++; if (seen !== 0) begin bad++; $display("FAIL noset_pready: got %0d completions want 0", seen); end
        total++; if (xfer_cnt_o !== cnt_m) begin bad++; $display("FAIL noset_cnt: got %0d want %0d", xfer_cnt_o, cnt_m); end
        apb_xfer(1'b0, BASE, 32'h0, 3'd2, rd, er, w, leak);
        model_xfer(1'b0, BASE, 32'h0, erd, eer);
        total++; if (rd !== erd || w !== 2) begin bad++; $display("FAIL noset_after: got data %h waits %0d want %h waits 2", rd, w, erd); end
        go_idle();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0, 1:    return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            2:       return BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            default: return ($urandom_range(0, 1) == 0) ? BASE - 32'(4 * $urandom_range(1, 4))
                                                       : BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 63));
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] rd, erd, a, wd; logic er, eer, leak, wr; logic [2:0] wc; int w;
        for (int n = 0; n < 60; n++) begin
            a  = rand_addr();
            wd = $urandom;
            wr = 1'($urandom_range(0, 1));
            wc = 3'($urandom_range(0, 7));
            apb_xfer(wr, a, wd, wc, rd, er, w, leak);
            model_xfer(wr, a, wd, erd, eer);
            total++;
            if (rd !== erd || er !== eer || w !== int'(wc) || leak !== 1'b0) begin
                bad++;
                $display("FAIL rand%0d: addr %h wr %b got data %h err %b waits %0d leak %b want data %h err %b waits %0d leak 0",
                         n, a, wr, rd, er, w, leak, erd, eer, wc);
            end
            if ($urandom_range(0, 3) == 0) go_idle();
        end
        go_idle();
        #1;
        total++; if (xfer_cnt_o !== cnt_m) begin bad++; $display("FAIL rand_cnt: got %0d want %0d", xfer_cnt_o, cnt_m); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait();
        test_errors();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_protocol_violation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

endmodule
